// File: rtl/coreabc_ram_loader.sv
// Byte-stream loader for the 128x8 CoreABC RAM: writes a stream from a base
// address (wrapping) and optionally reads the region back to verify a checksum.
//
// state   | meaning
// IDLE    | waiting for START; LEN=0 pulses DONE without leaving IDLE
// LOAD    | accepting stream bytes and issuing RAM writes
// GAP     | one quiet cycle so the last write lands before any read
// RDADDR  | issuing one read address per cycle over the loaded region
// RDTAIL  | capturing read data for the last address
// FINISH  | DONE pulse, ERROR valid
module coreabc_ram_loader #(
  parameter int ADDR_WIDTH = 7,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  start_i,
  input  logic [ADDR_WIDTH-1:0] base_i,
  input  logic [7:0]            len_i,
  input  logic                  verify_i,
  input  logic [DATA_WIDTH-1:0] s_data_i,
  input  logic                  s_valid_i,
  output logic                  s_ready_o,
  output logic [DATA_WIDTH-1:0] wd_o,
  output logic [ADDR_WIDTH-1:0] waddr_o,
  output logic                  wen_o,
  output logic [ADDR_WIDTH-1:0] raddr_o,
  input  logic [DATA_WIDTH-1:0] rd_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  error_o,
  output logic [DATA_WIDTH-1:0] checksum_o
);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] LOAD   = 3'd1;
  localparam logic [2:0] GAP    = 3'd2;
  localparam logic [2:0] RDADDR = 3'd3;
  localparam logic [2:0] RDTAIL = 3'd4;
  localparam logic [2:0] FINISH = 3'd5;

  localparam logic [7:0] MAX_LEN = 8'(2 ** ADDR_WIDTH);

  logic [2:0]            state_q, state_d;
  logic [ADDR_WIDTH-1:0] base_q, base_d;
  logic [7:0]            len_q, len_d;
  logic                  verify_q, verify_d;
  logic [7:0]            idx_q, idx_d;
  logic                  s_ready_q, s_ready_d;
  logic [DATA_WIDTH-1:0] wd_q, wd_d;
  logic [ADDR_WIDTH-1:0] waddr_q, waddr_d;
  logic                  wen_q, wen_d;
  logic [ADDR_WIDTH-1:0] raddr_q, raddr_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  error_q, error_d;
  logic [DATA_WIDTH-1:0] cksum_q, cksum_d;
  logic [DATA_WIDTH-1:0] rsum_q, rsum_d;
  logic                  rd_vld_q, rd_vld_d;
  logic [DATA_WIDTH-1:0] rsum_nxt;
  logic                  hs;

  always_comb begin
    state_d   = state_q;
    base_d    = base_q;
    len_d     = len_q;
    verify_d  = verify_q;
    idx_d     = idx_q;
    s_ready_d = s_ready_q;
    wd_d      = wd_q;
    waddr_d   = waddr_q;
    wen_d     = 1'b0;
    raddr_d   = raddr_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    error_d   = error_q;
    cksum_d   = cksum_q;
    rd_vld_d  = 1'b0;
    // read data belongs to the address driven in the previous cycle
    rsum_nxt  = rsum_q + (rd_vld_q ? rd_i : '0);
    rsum_d    = rsum_nxt;
    hs        = s_valid_i & s_ready_q;

    case (state_q)
      IDLE: begin
        if (start_i) begin
          error_d = 1'b0;
          cksum_d = '0;
          rsum_d  = '0;
          idx_d   = '0;
          if (len_i == 8'd0) begin
            done_d = 1'b1;
          end else begin
            base_d    = base_i;
            len_d     = (len_i > MAX_LEN) ? MAX_LEN : len_i;
            verify_d  = verify_i;
            s_ready_d = 1'b1;
            busy_d    = 1'b1;
            state_d   = LOAD;
          end
        end
      end
      LOAD: begin
        if (hs) begin
          wen_d   = 1'b1;
          wd_d    = s_data_i;
          waddr_d = base_q + idx_q[ADDR_WIDTH-1:0];
          cksum_d = cksum_q + s_data_i;
          idx_d   = idx_q + 8'd1;
          if (idx_q == len_q - 8'd1) s_ready_d = 1'b0;
        end else if (!s_ready_q) begin
          if (verify_q) begin
            state_d = GAP;
          end else begin
            state_d = FINISH;
            done_d  = 1'b1;
          end
        end
      end
      GAP: begin
        raddr_d = base_q;
        idx_d   = 8'd1;
        state_d = RDADDR;
      end
      RDADDR: begin
        rd_vld_d = 1'b1;
        if (idx_q == len_q) begin
          state_d = RDTAIL;
        end else begin
          raddr_d = base_q + idx_q[ADDR_WIDTH-1:0];
          idx_d   = idx_q + 8'd1;
        end
      end
      RDTAIL: begin
        state_d = FINISH;
        done_d  = 1'b1;
        error_d = verify_q & (rsum_nxt != cksum_q);
      end
      FINISH: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q   <= IDLE;
      base_q    <= '0;
      len_q     <= '0;
      verify_q  <= 1'b0;
      idx_q     <= '0;
      s_ready_q <= 1'b0;
      wd_q      <= '0;
      waddr_q   <= '0;
      wen_q     <= 1'b0;
      raddr_q   <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      error_q   <= 1'b0;
      cksum_q   <= '0;
      rsum_q    <= '0;
      rd_vld_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      base_q    <= base_d;
      len_q     <= len_d;
      verify_q  <= verify_d;
      idx_q     <= idx_d;
      s_ready_q <= s_ready_d;
      wd_q      <= wd_d;
      waddr_q   <= waddr_d;
      wen_q     <= wen_d;
      raddr_q   <= raddr_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      error_q   <= error_d;
      cksum_q   <= cksum_d;
      rsum_q    <= rsum_d;
      rd_vld_q  <= rd_vld_d;
    end
  end

  assign s_ready_o  = s_ready_q;
  assign wd_o       = wd_q;
  assign waddr_o    = waddr_q;
  assign wen_o      = wen_q;
  assign raddr_o    = raddr_q;
  assign busy_o     = busy_q;
  assign done_o     = done_q;
  assign error_o    = error_q;
  assign checksum_o = cksum_q;

endmodule

// File: tb/tb_coreabc_ram_loader.sv
// Bench for coreabc_ram_loader: table of transfers against a RAM model, with a
// write scoreboard, plus reset-abort and zero-length sequences.
module tb_coreabc_ram_loader;

  logic       clk = 1'b0;
  logic       reset, start, verify, s_valid, s_ready_o;
  logic [6:0] base, waddr_o, raddr_o;
  logic [7:0] len, s_data, wd_o, rd, checksum_o;
  logic       wen_o, busy_o, done_o, error_o;
  logic       corrupt_pulse;
  logic [7:0] mem [128];

  int tests = 0;
  int fails = 0;

  logic [14:0] wq[$];

  typedef struct {
    logic [6:0] base;
    logic [7:0] len;
    logic       verify;
    logic       sparse;
    logic [7:0] d0;
    logic [7:0] step;
    logic       corrupt;
    logic       start_spam;
    logic [7:0] exp_cksum;
    logic       exp_err;
    int         exp_done;
  } case_t;

  case_t cases[6];

  coreabc_ram_loader #(.ADDR_WIDTH(7), .DATA_WIDTH(8)) dut (
    .clk_i(clk), .reset_i(reset), .start_i(start), .base_i(base), .len_i(len),
    .verify_i(verify), .s_data_i(s_data), .s_valid_i(s_valid), .s_ready_o(s_ready_o),
    .wd_o(wd_o), .waddr_o(waddr_o), .wen_o(wen_o), .raddr_o(raddr_o), .rd_i(rd),
    .busy_o(busy_o), .done_o(done_o), .error_o(error_o), .checksum_o(checksum_o)
  );

  always #5 clk = ~clk;

  // synchronous-read RAM: data for RADDR appears one cycle later
  always @(posedge clk) begin
    if (wen_o) mem[waddr_o] <= wd_o;
    if (corrupt_pulse) mem[2] <= 8'h00;
    rd <= mem[raddr_o];
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] all_outs();
    return {s_ready_o, wen_o, busy_o, done_o, error_o, wd_o, waddr_o, raddr_o, checksum_o};
  endfunction

  task automatic run_case(input int n, input case_t c);
    int len_eff, idx, e_last, cyc, exp_done, done_at;
    bit hs, hs_prev, finished;
    logic [14:0] w;
    len_eff  = (c.len > 8'd128) ? 128 : int'(c.len);
    idx      = 0;
    e_last   = -1;
    hs_prev  = 0;
    done_at  = -1;
    finished = 0;
    wq.delete();
    start = 1'b1; base = c.base; len = c.len; verify = c.verify; s_valid = 1'b0;
    @(posedge clk); #1;
    cyc = 1;
    start = 1'b0;
    chk($sformatf("c%0d_start_clears", n), {error_o, checksum_o}, 0);
    for (int g = 0; g < 400; g++) begin
      exp_done = (idx < len_eff) ? -1 : e_last + (c.verify ? len_eff + 4 : 2);
      chk($sformatf("c%0d_s_ready@%0d", n, cyc), s_ready_o, idx < len_eff);
      chk($sformatf("c%0d_wen@%0d", n, cyc), wen_o, hs_prev);
      if (wen_o) begin
        if (wq.size() > 0) begin
          w = wq.pop_front();
          chk($sformatf("c%0d_write@%0d", n, cyc), {waddr_o, wd_o}, w);
        end else begin
          chk($sformatf("c%0d_unexpected_write@%0d", n, cyc), wen_o, 0);
        end
      end
      chk($sformatf("c%0d_busy@%0d", n, cyc), busy_o, exp_done < 0 || cyc <= exp_done);
      chk($sformatf("c%0d_done@%0d", n, cyc), done_o, cyc == exp_done);
      if (done_o && done_at < 0) done_at = cyc;
      if (c.verify && exp_done >= 0 && cyc >= e_last + 3 && cyc <= e_last + len_eff + 2)
        chk($sformatf("c%0d_raddr@%0d", n, cyc), raddr_o, 7'(c.base + (cyc - e_last - 3)));
      if (exp_done >= 0 && cyc == exp_done) begin
        chk($sformatf("c%0d_checksum", n), checksum_o, c.exp_cksum);
        chk($sformatf("c%0d_error", n), error_o, c.exp_err);
      end
      if (exp_done >= 0 && cyc == exp_done + 3) begin
        chk($sformatf("c%0d_error_held", n), error_o, c.exp_err);
        finished = 1;
        break;
      end
      corrupt_pulse = c.corrupt && exp_done >= 0 && cyc == e_last + 2;
      start   = c.start_spam && cyc >= 2 && cyc <= 6;
      len     = start ? 8'd5 : c.len;
      s_valid = c.sparse ? cyc[0] : 1'b1;
      s_data  = 8'(c.d0 + idx * c.step);
      hs      = s_valid && (idx < len_eff);
      if (hs) begin
        wq.push_back({7'(c.base + idx), s_data});
        idx++;
        e_last = cyc;
      end
      hs_prev = hs;
      @(posedge clk); #1;
      cyc++;
    end
    start = 1'b0; s_valid = 1'b0; corrupt_pulse = 1'b0;
    chk($sformatf("c%0d_finished_in_budget", n), finished, 1);
    chk($sformatf("c%0d_writes_drained", n), wq.size(), 0);
    if (c.exp_done > 0) chk($sformatf("c%0d_done_cycle", n), done_at, c.exp_done);
  endtask

  initial begin
    cases[0] = '{7'd0,   8'd4,   1'b0, 1'b0, 8'h11, 8'h11, 1'b0, 1'b0, 8'hAA, 1'b0, 6};
    cases[1] = '{7'd126, 8'd4,   1'b1, 1'b1, 8'h01, 8'h01, 1'b0, 1'b0, 8'h0A, 1'b0, 15};
    cases[2] = '{7'd5,   8'd128, 1'b1, 1'b0, 8'hFF, 8'h00, 1'b0, 1'b0, 8'h80, 1'b0, 260};
    cases[3] = '{7'd0,   8'd4,   1'b1, 1'b0, 8'h11, 8'h11, 1'b1, 1'b0, 8'hAA, 1'b1, 12};
    cases[4] = '{7'd64,  8'd200, 1'b0, 1'b0, 8'h00, 8'h01, 1'b0, 1'b0, 8'hC0, 1'b0, 130};
    cases[5] = '{7'd100, 8'd20,  1'b1, 1'b0, 8'h37, 8'h0D, 1'b0, 1'b1, 8'hF2, 1'b0, 44};

    reset = 1'b1; start = 1'b0; base = '0; len = '0; verify = 1'b0;
    s_valid = 1'b0; s_data = '0; corrupt_pulse = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_state", all_outs(), 0);
    reset = 1'b0;

    // reset in the middle of a LEN=10 load after five bytes
    start = 1'b1; base = 7'd10; len = 8'd10; verify = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      s_valid = 1'b1;
      s_data  = 8'(8'h50 + i);
      @(posedge clk); #1;
    end
    chk("pre_reset_wen", {wen_o, waddr_o, wd_o}, {1'b1, 7'd14, 8'h54});
    reset = 1'b1;
    @(posedge clk); #1;
    chk("reset_abort_outs", all_outs(), 0);
    @(posedge clk); #1;
    reset = 1'b0; s_valid = 1'b0;
    chk("reset_hold_outs", all_outs(), 0);
    @(posedge clk); #1;
    chk("no_done_after_reset", {busy_o, done_o}, 0);
    chk("ram_kept_data", mem[14], 8'h54);

    for (int i = 0; i < 6; i++) run_case(i, cases[i]);

    // zero-length transfer: immediate DONE, no RAM traffic, checksum cleared
    start = 1'b1; base = 7'd33; len = 8'd0; verify = 1'b1; s_valid = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("len0_done", {done_o, busy_o, wen_o, s_ready_o, checksum_o}, {1'b1, 1'b0, 1'b0, 1'b0, 8'h00});
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk($sformatf("len0_quiet%0d", i), {done_o, busy_o, wen_o, s_ready_o}, 0);
    end
    s_valid = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
